muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM.
- Sits beside the main ALU in the execute stage. It accepts one M-extension operation per request and computes it over XLEN iterations.
- Raises a stall to the pipeline control while it works, and pulses done with a held result.
- Handles all eight M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  XLEN  operand A (multiplicand / dividend)
- rs2  input  XLEN  operand B (multiplier / divisor)
- busy  output  1  high in MUL and DIV states
- done  output  1  one-cycle pulse in DONE state
- stall  output  1  combinational: (start & state==IDLE) | busy
- result  output  XLEN  registered result; valid from done, held until next accepted start or rst

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE; result, busy and done go to 0; internal accumulators and counter clear.
  - Reset overrides any in-flight operation; no done pulse follows.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 latches funct3 and the operands.
  - Operands are made absolute for signed ops: rs1 for MULH, MULHSU, DIV and REM; rs2 for MULH, DIV and REM.
  - The result sign is recorded.
  - Next state: MUL if funct3[2]=0, else DIV.
  - Special case: DIV/REM/DIVU/REMU with rs2==0 goes to DONE directly.
  - Special case: signed DIV/REM with rs1=0x8000_0000 and rs2=0xFFFF_FFFF goes to DONE directly.
  - start=0: remain in IDLE.
- MUL:
  - Shift-add over a 2*XLEN product register, one multiplier bit per cycle, counter 0..XLEN-1.
  - After XLEN cycles go to DONE.
  - The product is negated (two's complement, 2*XLEN wide) if the recorded sign is negative.
  - MUL selects the low XLEN bits of the product; MULH, MULHSU and MULHU select the high XLEN bits.
- DIV:
  - Restoring division, one quotient bit per cycle, XLEN cycles, then DONE.
  - Quotient sign = sign(rs1) XOR sign(rs2) for signed ops; remainder sign = sign(rs1).
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- Divide by zero:
  - Quotient = all ones (0xFFFF_FFFF), both signed and unsigned.
  - Remainder = rs1 unmodified.
- Signed overflow (-2^31 / -1): quotient = 0x8000_0000, remainder = 0.
- DONE:
  - result register loaded on entry; done=1 for exactly one cycle.
  - Next state: IDLE unconditionally; start is ignored in DONE.
- Latency, with the start cycle as cycle 0:
  - Normal op: done at cycle XLEN+1 (33).
  - Special-case divide: done at cycle 1.
- Stall:
  - High from cycle 0 through the last busy cycle. Low in the DONE cycle, so the pipeline consumes result on done.
- start while busy or in DONE: ignored; no queueing.
- Operand inputs may change after cycle 0 without effect.

Test Plan:
- MUL rs1=7, rs2=6, start 1 cycle -> stall high cycles 0..32, done at cycle 33, result=42, busy low at 33.
- MULH rs1=0xFFFF_FFFF (-1), rs2=0xFFFF_FFFF -> result 0x0000_0000. MULHU same operands -> 0xFFFF_FFFE. MULHSU rs1=-1, rs2=2 -> 0xFFFF_FFFF.
- DIV rs1=-7 (0xFFFF_FFF9), rs2=2 -> result 0xFFFF_FFFD (-3). REM same operands -> 0xFFFF_FFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2. Each done at cycle 33.
- DIV/REM with rs2=0, rs1=0x1234 -> done at cycle 1. DIV result 0xFFFF_FFFF; REM result 0x1234.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> done at cycle 1, result 0x8000_0000. REM with the same operands -> 0.
- Control sequencing:
  - rst asserted at cycle 10 of a MUL -> state IDLE, busy/done/result 0, no done pulse.
  - start held high continuously -> back-to-back ops, each taking 34 cycles (start-to-start), with done pulses 34 cycles apart.
  - start pulsed while busy -> ignored.

Source files
------------

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide unit with sequencing FSM
//
// Purpose: executes one M-extension op per accepted request. Multiplies use
// XLEN shift-add steps and divides use XLEN restoring steps. A divide by zero
// and a signed -2^(XLEN-1)/-1 are resolved in one cycle.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request, only sampled while idle
//   funct3 - M op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1    - operand A (multiplicand / dividend)
//   rs2    - operand B (multiplier / divisor)
//   busy   - high while iterating (MUL or DIV state)
//   done   - one-cycle pulse when result becomes valid
//   stall  - combinational pipeline hold: (start while idle) or busy
//   result - registered result, held until the next accepted start or rst
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_op;      // funct3[1:0]; funct3[2] is implied by the state
  logic                r_neg;     // product / quotient sign
  logic                r_neg_r;   // remainder sign
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_prod;    // {partial high, remaining multiplier bits}
  logic [XLEN-1:0]     r_mcand;   // multiplicand, or divisor in DIV
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;     // dividend shifts out as quotient shifts in
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  // Operand conditioning in IDLE
  logic            w_s1_op, w_s2_op, w_rs1_sgn, w_rs2_sgn;
  logic [XLEN-1:0] w_a_abs, w_b_abs;
  logic            w_div_zero, w_div_ovf, w_div_special;
  logic [XLEN-1:0] w_spec_res;

  assign w_s1_op   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_s2_op   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_rs1_sgn = w_s1_op & rs1[XLEN-1];
  assign w_rs2_sgn = w_s2_op & rs2[XLEN-1];
  assign w_a_abs   = w_rs1_sgn ? -rs1 : rs1;
  assign w_b_abs   = w_rs2_sgn ? -rs2 : rs2;

  assign w_div_zero    = funct3[2] && (rs2 == '0);
  assign w_div_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                         (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign w_div_special = w_div_zero || w_div_ovf;
  // funct3[1] distinguishes REM/REMU from DIV/DIVU
  assign w_spec_res    = w_div_zero ? (funct3[1] ? rs1 : '1)
                                    : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right by one.
  logic [XLEN-1:0]   w_add;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod_nxt, w_prod_fin;
  logic [XLEN-1:0]   w_mul_res;

  assign w_add      = r_prod[0] ? r_mcand : '0;
  assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, w_add};
  assign w_prod_nxt = {w_sum, r_prod[XLEN-1:1]};
  assign w_prod_fin = r_neg ? -w_prod_nxt : w_prod_nxt;
  assign w_mul_res  = (r_op == 2'b00) ? w_prod_fin[XLEN-1:0] : w_prod_fin[2*XLEN-1:XLEN];

  // Restoring step: bit XLEN of the difference is the borrow (trial failed).
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_div_res;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_mcand};
  assign w_rem_nxt = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
  assign w_div_res = r_op[1] ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                             : (r_neg   ? -w_quo_nxt : w_quo_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= funct3[1:0];
            r_neg   <= w_rs1_sgn ^ w_rs2_sgn;
            r_neg_r <= w_rs1_sgn;
            r_cnt   <= '0;
            r_mcand <= funct3[2] ? w_b_abs : w_a_abs;
            r_prod  <= {{XLEN{1'b0}}, w_b_abs};
            r_quo   <= w_a_abs;
            r_rem   <= '0;
            if (w_div_special) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= funct3[2] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN-1)) begin
            r_result <= w_mul_res;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN-1)) begin
            r_result <= w_div_res;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign stall  = (start && (r_state == S_IDLE)) || r_busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, stall;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done),
    .stall(stall), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at a negedge (cycle 0), then sample each following negedge.
  // glitch>0 pulses start with a different op during that busy cycle.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input int glitch);
    int  cyc;
    bit  got;
    got = 1'b0;
    cyc = 0;
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    #1 chk({tag, "_stall_c0"}, stall, 1'b1);
    @(posedge clk);
    #1 start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      start = (k == glitch);
      if (glitch != 0 && k == glitch) funct3 = 3'b101;
      if (done) begin
        got = 1'b1;
        cyc = k;
      end else begin
        chk({tag, "_stall_busy"}, stall, 1'b1);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_stall_done"}, stall, 1'b0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_result_held"}, result, exp);
  endtask

  int d1, d2, nd;

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // Multiplies
    do_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42,        33, 5);
    do_op("mul_m1x3",    3'b000, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD,  33, 0);
    do_op("mulh_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,  33, 0);
    do_op("mulhu_ff",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  33, 0);
    do_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF,  33, 0);

    // Divides
    do_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  33, 0);
    do_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  33, 0);
    do_op("div_7_m2",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  33, 0);
    do_op("rem_7_m2",    3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,         33, 0);
    do_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,        33, 0);
    do_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,         33, 0);
    do_op("divu_min_m1", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,         33, 0);

    // Special cases
    do_op("div_by0",     3'b100, 32'h1234,     32'd0,        32'hFFFFFFFF,  1, 0);
    do_op("rem_by0",     3'b110, 32'h1234,     32'd0,        32'h1234,      1, 0);
    do_op("divu_by0",    3'b101, 32'h55,       32'd0,        32'hFFFFFFFF,  1, 0);
    do_op("remu_by0",    3'b111, 32'h55,       32'd0,        32'h55,        1, 0);
    do_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1, 0);
    do_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,         1, 0);

    // Reset in the middle of a multiply
    do_op("mul_pre_rst", 3'b000, 32'd9,        32'd9,        32'd81,        33, 0);
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_stall", stall, 1'b0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", 32'(nd), 32'd0);

    // start held high: back-to-back ops, 34 cycles apart
    @(negedge clk);
    funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 100 && d2 < 0; k++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_stall_done", stall, 1'b0);
        chk("b2b_result", result, 32'd14);
        if (d1 < 0) d1 = k;
        else d2 = k;
      end
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(d1), 32'd33);
    chk("b2b_spacing", 32'(d2 - d1), 32'd34);
    repeat (40) @(negedge clk);
    chk("b2b_quiet_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
